// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Arbiter ownership state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // One-hot grant encodings, also used on the o_grant port.
  localparam logic [1:0] GNT_IDLE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational 2-way round-robin picker: one-hot grant from two requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; on a tie the master that did not own last wins.
// Ports: i_req[1:0] (bit0=M0, bit1=M1), i_last_m1 (1 = M1 owned last),
//        o_gnt[1:0] one-hot winner, 00 when nobody requests.
module wb_rr_pick
  import wb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_m1,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = GNT_IDLE;
    if (i_req == 2'b11) begin
      o_gnt = i_last_m1 ? GNT_M0 : GNT_M1;
    end else begin
      // Zero or one request: the request vector is already one-hot.
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave pipelined Wishbone arbiter, round-robin, grant held for the bus cycle.
// Latency: grant 1 cycle after cyc; owner-to-slave signals forwarded combinationally; 1 dead cycle between owners.
// Backpressure: owner sees slave stall, plus stall while a request is outstanding; non-owner always stalled.
// Ports: clk/reset (async active-high); i_mX_* master requests; o_mX_* ack/err/stall/read data to
//        each master; o_s_* / i_s_* the shared slave port; o_grant one-hot current owner.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16,  // cycles a granted request may wait for ack, 2..255
  parameter int CNT_W   = 8    // timeout counter width, must hold TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_m0_cyc,
  input  logic              i_m0_stb,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_data,
  input  logic              i_m1_cyc,
  input  logic              i_m1_stb,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_data,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  output logic              o_m0_stall,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic              o_m1_stall,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_s_cyc,
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_data,
  input  logic              i_s_ack,
  input  logic              i_s_stall,
  input  logic [DATA_W-1:0] i_s_data,
  output logic [1:0]        o_grant
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last_m1;
  logic              r_pending;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_pick;
  logic              w_m_cyc;
  logic              w_m_stb;
  logic              w_m_we;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_data;
  logic              w_blocked;
  logic              w_timeout;
  logic              w_accept;
  logic              w_owner_stall;

  wb_rr_pick u_pick (
    .i_req     ({i_m1_cyc, i_m0_cyc}),
    .i_last_m1 (r_last_m1),
    .o_gnt     (w_pick)
  );

  // Select the owning master's request signals; all zero while idle.
  always_comb begin
    w_m_cyc  = 1'b0;
    w_m_stb  = 1'b0;
    w_m_we   = 1'b0;
    w_m_addr = '0;
    w_m_data = '0;
    if (r_state == ST_OWN0) begin
      w_m_cyc  = i_m0_cyc;
      w_m_stb  = i_m0_stb;
      w_m_we   = i_m0_we;
      w_m_addr = i_m0_addr;
      w_m_data = i_m0_data;
    end else if (r_state == ST_OWN1) begin
      w_m_cyc  = i_m1_cyc;
      w_m_stb  = i_m1_stb;
      w_m_we   = i_m1_we;
      w_m_addr = i_m1_addr;
      w_m_data = i_m1_data;
    end
  end

  // One outstanding request at a time; an ack this cycle frees the slot
  // immediately so a back-to-back strobe can be accepted alongside it.
  assign w_blocked     = r_pending && !i_s_ack;
  // An ack arriving on the last allowed cycle wins over the timeout.
  assign w_timeout     = w_m_cyc && r_pending && !i_s_ack && (r_cnt == TO_LAST);
  assign o_s_cyc       = w_m_cyc && !w_timeout;
  // Strobe is masked while blocked so the slave never sees a second request
  // that the master has been told is stalled.
  assign o_s_stb       = o_s_cyc && w_m_stb && !w_blocked;
  assign o_s_we        = w_m_we;
  assign o_s_addr      = w_m_addr;
  assign o_s_data      = w_m_data;
  assign w_accept      = o_s_stb && !i_s_stall;
  assign w_owner_stall = i_s_stall || w_blocked;

  // Per-master return path; the non-owner stays stalled and sees nothing.
  always_comb begin
    o_m0_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_data  = '0;
    o_m1_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_data  = '0;
    case (r_state)
      ST_OWN0: begin
        o_m0_stall = w_owner_stall;
        o_m0_ack   = i_s_ack;
        o_m0_err   = w_timeout;
        o_m0_data  = i_s_data;
      end
      ST_OWN1: begin
        o_m1_stall = w_owner_stall;
        o_m1_ack   = i_s_ack;
        o_m1_err   = w_timeout;
        o_m1_data  = i_s_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_grant = GNT_IDLE;
    case (r_state)
      ST_OWN0: o_grant = GNT_M0;
      ST_OWN1: o_grant = GNT_M1;
      default: o_grant = GNT_IDLE;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick == GNT_M0) begin
          w_state_nxt = ST_OWN0;
        end else if (w_pick == GNT_M1) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_m_cyc || w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_last_m1 <= 1'b1;  // so M0 wins the first tie
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        if (w_state_nxt == ST_OWN0) begin
          r_last_m1 <= 1'b0;
        end else if (w_state_nxt == ST_OWN1) begin
          r_last_m1 <= 1'b1;
        end
      end
      // Release, timeout or idle drops any outstanding request; a late ack
      // then lands in IDLE and is discarded.
      if (r_state == ST_IDLE || !w_m_cyc || w_timeout) begin
        r_pending <= 1'b0;
        r_cnt     <= '0;
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_cnt     <= '0;
      end else if (i_s_ack) begin
        r_pending <= 1'b0;
        r_cnt     <= '0;
      end else if (r_pending) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_m0_cyc, i_m0_stb, i_m0_we;
  logic [31:0] i_m0_addr, i_m0_data;
  logic        i_m1_cyc, i_m1_stb, i_m1_we;
  logic [31:0] i_m1_addr, i_m1_data;
  logic        o_m0_ack, o_m0_err, o_m0_stall;
  logic [31:0] o_m0_data;
  logic        o_m1_ack, o_m1_err, o_m1_stall;
  logic [31:0] o_m1_data;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [31:0] o_s_addr, o_s_data;
  logic        i_s_ack, i_s_stall;
  logic [31:0] i_s_data;
  logic [1:0]  o_grant;

  typedef struct packed {
    logic        mst;
    logic        err;
    logic [31:0] data;
    logic [31:0] cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] cyc_cnt = 32'd0;
  logic [31:0] acc;

  wb_arbiter_2m #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_m0_cyc   (i_m0_cyc),
    .i_m0_stb   (i_m0_stb),
    .i_m0_we    (i_m0_we),
    .i_m0_addr  (i_m0_addr),
    .i_m0_data  (i_m0_data),
    .i_m1_cyc   (i_m1_cyc),
    .i_m1_stb   (i_m1_stb),
    .i_m1_we    (i_m1_we),
    .i_m1_addr  (i_m1_addr),
    .i_m1_data  (i_m1_data),
    .o_m0_ack   (o_m0_ack),
    .o_m0_err   (o_m0_err),
    .o_m0_stall (o_m0_stall),
    .o_m0_data  (o_m0_data),
    .o_m1_ack   (o_m1_ack),
    .o_m1_err   (o_m1_err),
    .o_m1_stall (o_m1_stall),
    .o_m1_data  (o_m1_data),
    .o_s_cyc    (o_s_cyc),
    .o_s_stb    (o_s_stb),
    .o_s_we     (o_s_we),
    .o_s_addr   (o_s_addr),
    .o_s_data   (o_s_data),
    .i_s_ack    (i_s_ack),
    .i_s_stall  (i_s_stall),
    .i_s_data   (i_s_data),
    .o_grant    (o_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  function automatic ev_t mk(input logic m, input logic e, input logic [31:0] d, input logic [31:0] c);
    ev_t r;
    r.mst  = m;
    r.err  = e;
    r.data = d;
    r.cyc  = c;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  // Expected ack/err event, due in the current cycle.
  task automatic expect_ev(input logic m, input logic e, input logic [31:0] d);
    exp_q.push_back(mk(m, e, d, cyc_cnt));
  endtask

  task automatic sb_take(input ev_t got);
    ev_t want;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL sb_unexpected: got m%0d err=%0b data=%h cyc=%0d, none expected",
               got.mst, got.err, got.data, got.cyc);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_mis++;
        $display("FAIL sb_event: got m%0d err=%0b data=%h cyc=%0d expected m%0d err=%0b data=%h cyc=%0d",
                 got.mst, got.err, got.data, got.cyc, want.mst, want.err, want.data, want.cyc);
      end
    end
  endtask

  // Monitor: every ack/err pulse the DUT presents must match the next expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (o_m0_ack) sb_take(mk(1'b0, 1'b0, o_m0_data, cyc_cnt));
      if (o_m1_ack) sb_take(mk(1'b1, 1'b0, o_m1_data, cyc_cnt));
      if (o_m0_err) sb_take(mk(1'b0, 1'b1, o_m0_data, cyc_cnt));
      if (o_m1_err) sb_take(mk(1'b1, 1'b1, o_m1_data, cyc_cnt));
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic idle_all();
    i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_addr = 0; i_m0_data = 0;
    i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_addr = 0; i_m1_data = 0;
    i_s_ack = 0; i_s_stall = 0; i_s_data = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    nc();
    nc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_all();
    half();
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_m0_stall", o_m0_stall, 1);
    chk("rst_m1_stall", o_m1_stall, 1);
    chk("rst_s_cyc_stb", {o_s_cyc, o_s_stb}, 2'b00);
    chk("rst_ack_err", {o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, 4'b0000);
    nc();
    reset = 1'b0;

    // M0 alone writes 0xA5 to 0x3000_0000, slave acks one cycle after strobe.
    nc();
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 1; i_m0_addr = 32'h3000_0000; i_m0_data = 32'h0000_00A5;
    half();
    chk("t1_idle_grant", o_grant, 2'b00);
    chk("t1_idle_m0_stall", o_m0_stall, 1);
    nc();
    half();
    chk("t1_grant", o_grant, 2'b01);
    chk("t1_s_addr", o_s_addr, 32'h3000_0000);
    chk("t1_s_data", o_s_data, 32'h0000_00A5);
    chk("t1_s_we_stb", {o_s_we, o_s_stb}, 2'b11);
    chk("t1_m0_stall", o_m0_stall, 0);
    chk("t1_m1_stall", o_m1_stall, 1);
    nc();
    i_m0_stb = 0; i_s_ack = 1;
    expect_ev(1'b0, 1'b0, 32'h0);
    half();
    chk("t1_m1_stall_ack", o_m1_stall, 1);
    nc();
    i_s_ack = 0; i_m0_cyc = 0; i_m0_we = 0;
    half();
    chk("t1_release_s_cyc", o_s_cyc, 0);
    chk("t1_release_grant", o_grant, 2'b01);
    nc();
    half();
    chk("t1_after_grant", o_grant, 2'b00);

    // Simultaneous requests: round-robin ordering.
    do_reset();
    i_m0_cyc = 1; i_m1_cyc = 1;
    half();
    chk("t2_idle_grant", o_grant, 2'b00);
    nc();
    half();
    chk("t2_tie_m0", o_grant, 2'b01);
    chk("t2_m1_stalled", o_m1_stall, 1);
    nc();
    i_m0_cyc = 0;
    half();
    chk("t2_release_s_cyc", o_s_cyc, 0);
    nc();
    half();
    chk("t2_dead_cycle", o_grant, 2'b00);
    nc();
    half();
    chk("t2_m1_owns", o_grant, 2'b10);
    chk("t2_m1_s_cyc", o_s_cyc, 1);
    nc();
    i_m1_cyc = 0;
    nc();
    i_m0_cyc = 1; i_m1_cyc = 1;
    nc();
    half();
    chk("t2_tie_after_m1", o_grant, 2'b01);
    nc();
    i_m0_cyc = 0; i_m1_cyc = 0;
    nc();
    i_m0_cyc = 1; i_m1_cyc = 1;
    nc();
    half();
    chk("t2_tie_after_m0", o_grant, 2'b10);
    nc();
    i_m0_cyc = 0; i_m1_cyc = 0;
    nc();

    // M1: three back-to-back reads of 0x3000_0004, slave returns 5.
    nc();
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_we = 0; i_m1_addr = 32'h3000_0004;
    half();
    chk("t3_m0_stall_idle", o_m0_stall, 1);
    nc();
    half();
    chk("t3_grant", o_grant, 2'b10);
    chk("t3_s_addr", o_s_addr, 32'h3000_0004);
    chk("t3_m1_stall", o_m1_stall, 0);
    chk("t3_m0_stall", o_m0_stall, 1);
    for (int k = 0; k < 3; k++) begin
      nc();
      i_s_ack = 1; i_s_data = 32'h0000_0005;
      if (k == 2) i_m1_stb = 0;
      expect_ev(1'b1, 1'b0, 32'h0000_0005);
      half();
      chk("t3_m0_stall_burst", o_m0_stall, 1);
      chk("t3_m0_data_zero", o_m0_data, 32'h0);
    end
    nc();
    i_s_ack = 0; i_s_data = 0; i_m1_cyc = 0;
    nc();

    // M0 read never acked: error exactly 8 cycles after accept, late ack dropped.
    nc();
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 32'h3000_0000;
    nc();
    half();
    chk("t4_grant", o_grant, 2'b01);
    chk("t4_accept_stb", o_s_stb, 1);
    acc = cyc_cnt;
    nc();
    i_m0_stb = 0;
    for (int i = 2; i < 8; i++) begin
      nc();
      half();
      chk("t4_wait_s_cyc", o_s_cyc, 1);
      chk("t4_wait_m0_stall", o_m0_stall, 1);
    end
    nc();
    chk("t4_err_cycle_index", cyc_cnt - acc, 32'd8);
    expect_ev(1'b0, 1'b1, 32'h0);
    half();
    chk("t4_err_s_cyc", o_s_cyc, 0);
    nc();
    i_m0_cyc = 0;
    half();
    chk("t4_idle_grant", o_grant, 2'b00);
    nc();
    i_s_ack = 1; i_s_data = 32'hDEAD_BEEF;
    half();
    chk("t4_late_ack", o_m0_ack, 0);
    chk("t4_late_data", o_m0_data, 32'h0);
    nc();
    i_s_ack = 0; i_s_data = 0;

    // M1 write with slave stall for 3 cycles; ack on the last allowed cycle.
    nc();
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_we = 1; i_m1_addr = 32'h3000_0000;
    i_m1_data = 32'h0000_0033; i_s_stall = 1;
    for (int i = 0; i < 3; i++) begin
      nc();
      half();
      chk("t5_stall_mirror", o_m1_stall, 1);
      chk("t5_stb_held", o_s_stb, 1);
    end
    nc();
    i_s_stall = 0;
    half();
    chk("t5_unstall", o_m1_stall, 0);
    chk("t5_s_data", o_s_data, 32'h0000_0033);
    acc = cyc_cnt;
    nc();
    i_m1_stb = 0;
    for (int i = 2; i < 8; i++) begin
      nc();
      half();
      chk("t5_pending_stall", o_m1_stall, 1);
    end
    nc();
    i_s_ack = 1;
    expect_ev(1'b1, 1'b0, 32'h0);
    half();
    chk("t5_ack_cycle_index", cyc_cnt - acc, 32'd8);
    chk("t5_ack_unstall", o_m1_stall, 0);
    nc();
    i_s_ack = 0; i_m1_cyc = 0; i_m1_we = 0;
    nc();

    // Reset mid-transaction while M1 owns with a request pending.
    nc();
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_addr = 32'h3000_0004;
    nc();
    half();
    chk("t6_grant", o_grant, 2'b10);
    nc();
    i_m1_stb = 0;
    reset = 1'b1;
    #2;
    chk("t6_rst_s_cyc", o_s_cyc, 0);
    chk("t6_rst_grant", o_grant, 2'b00);
    chk("t6_rst_stalls", {o_m0_stall, o_m1_stall}, 2'b11);
    nc();
    i_m0_cyc = 1;
    reset = 1'b0;
    half();
    chk("t6_idle_grant", o_grant, 2'b00);
    nc();
    half();
    chk("t6_m0_wins", o_grant, 2'b01);
    nc();
    idle_all();
    nc();
    nc();

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master, one-slave Wishbone (pipelined, classic single-beat) arbiter.
It shares one user-area peripheral (e.g. the LED/button register block at 0x3000_0000) between the management-core master (M0) and a second in-design master (M1).
Round-robin grant held for the whole bus cycle (cyc high), with a per-request ack timeout that returns an error pulse and releases the bus.

Parameters:
TIMEOUT, 16, cycles a granted request may wait for slave ack before error; range 2..255
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_m0_cyc, i_m1_cyc  input  1 each  master bus cycle request
i_m0_stb, i_m1_stb  input  1 each  master strobe
i_m0_we, i_m1_we  input  1 each  master write enable
i_m0_addr, i_m1_addr  input  32 each  master address
i_m0_data, i_m1_data  input  32 each  master write data
o_m0_ack, o_m1_ack  output  1 each  ack routed to owning master
o_m0_err, o_m1_err  output  1 each  one-cycle timeout error pulse
o_m0_stall, o_m1_stall  output  1 each  master stall
o_m0_data, o_m1_data  output  32 each  read data routed to owning master
o_s_cyc, o_s_stb, o_s_we  output  1 each  slave control
o_s_addr, o_s_data  output  32 each  slave address / write data
i_s_ack  input  1  slave ack
i_s_stall  input  1  slave stall
i_s_data  input  32  slave read data
o_grant  output  2  one-hot current owner (01=M0, 10=M1, 00=idle)

Behaviour:
- Reset (async, immediate): state IDLE, last_owner=M1 (so M0 wins the first tie), pending=0, counter=0. All outputs are 0 except o_m0_stall=o_m1_stall=1.
- States: IDLE, OWN0, OWN1.
- IDLE: both masters stalled; slave cyc/stb=0.
  - Only Mx cyc high -> OWNx next cycle.
  - Both high -> owner is the master not equal to last_owner.
  - Neither -> stay in IDLE.
  - Arbitration latency is exactly 1 cycle.
- OWNx:
  - o_s_cyc=i_mx_cyc; o_s_stb=i_mx_stb; we/addr/data are forwarded from Mx combinationally.
  - o_mx_stall=i_s_stall; o_mx_ack=i_s_ack; o_mx_data=i_s_data.
  - Non-owner: stall=1, ack=0, err=0, data=0.
  - last_owner<=x on entry.
- Release: i_mx_cyc low while in OWNx -> o_s_cyc drops the same cycle and state returns to IDLE next cycle.
  - A waiting master is granted one cycle after that (one dead cycle between owners).
- Pending tracking:
  - pending set when o_s_stb && !i_s_stall; cleared on i_s_ack.
  - Only one outstanding request is allowed: the owner sees stall=1 while pending && !i_s_ack.
  - Accept plus ack in the same cycle leaves pending=1 (new request).
- Timeout:
  - counter resets to 0 on each accept and counts while pending.
  - When counter==TIMEOUT-1 without ack: o_mx_err=1 for one cycle, pending=0, o_s_cyc forced 0 that cycle, state -> IDLE.
  - Ack and timeout in the same cycle: ack wins, no err.
- Slave ack while IDLE (late ack after timeout) is discarded; neither master sees it.
- Master cyc dropping while pending: bus released anyway and pending cleared; the late ack is discarded.
- o_grant reflects state registered (00 in IDLE).

Decomposition:
- Shared package (wb_pkg): state encoding constants (IDLE/OWN0/OWN1), grant one-hot constants, Wishbone widths (ADDR_W=32, DATA_W=32).
- One natural sub-module: wb_rr_pick, a combinational 2-way round-robin picker taking req[1:0] and last_owner and returning a one-hot grant.
- Muxing and the timeout logic stay in the top module.

Test Plan:
- M0 alone writes 0x0000_00A5 to 0x3000_0000; slave acks 1 cycle after stb -> o_grant=01 one cycle after cyc; o_m0_ack=1; o_m1_stall=1 throughout; grant 00 after cyc drops.
- M0 and M1 raise cyc in the same cycle after reset -> M0 owns first. M1 owns after M0 drops cyc plus 1 idle cycle. Repeat the simultaneous request -> M1 wins.
- M1 holds cyc across 3 back-to-back reads of 0x3000_0004 (slave returns 0x0000_0005) -> three o_m1_ack pulses, o_m1_data=5, M0 stalled all cycles.
- TIMEOUT=8, slave never acks an M0 read -> o_m0_err pulses exactly 8 cycles after accept; o_s_cyc=0; a later slave ack is not routed to M0.
- Slave i_s_stall=1 for 3 cycles on an M1 write -> o_m1_stall mirrors it, counter not started, single accept when stall drops.
- Reset asserted mid-transaction while OWN1 and pending -> same cycle: o_s_cyc=0, o_grant=00, both stalls=1; after release, M0 wins the next tie.
